disp_value_seq: RTL and testbench
=================================

# disp_value_seq

Sequencer in front of the 8-digit display controller. Accepts a binary value with a start/busy/done handshake and converts it to eight BCD digits with an iterative shift-add-3 (double-dabble) loop. It then streams the digits into the display controller's `dig`/`pos` write port, one digit per cycle, from least-significant to most-significant. It sits between the calculator result path and the display controller and is that controller's only writer.

## Interface
- `VALUE_W`, default 27: width of the binary input. Must be ≥ 27 so that 99_999_999 is representable.
- `NUM_DIGITS`, default 8: number of display positions written.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `value`  in  VALUE_W  binary value; captured on the accepted `start` edge.
- `busy`  out  1  high from the cycle after an accepted start through the last WRITE cycle.
- `done`  out  1  one-cycle pulse after the last digit write.
- `err`  out  1  overflow flag; sticky until the next accepted start or reset.
- `dig`  out  4  BCD digit to the display controller.
- `pos`  out  4  digit position, 0..7. Idle code is 4'hF, which the display controller ignores.

## Operation
- States: IDLE → CONVERT → WRITE → DONE → IDLE.
- IDLE:
  - Outputs: `pos`=4'hF, `dig`=0, `busy`=0.
  - `start`=1 captures `value`, clears `err` and the BCD register, sets the bit counter to VALUE_W-1, and moves to CONVERT.
- CONVERT, one input bit per cycle for VALUE_W cycles:
  - Each BCD nibble ≥ 5 gets +3 added first.
  - The {BCD, binary} register then shifts left by 1.
  - After the last bit, go to WRITE with the digit index at 0.
- WRITE, NUM_DIGITS cycles:
  - `pos` = index, `dig` = BCD nibble[index].
  - Index increments each cycle; after index 7, go to DONE.
- DONE, one cycle: `done`=1, `busy`=0, `pos`=4'hF. Next state is IDLE.
- Overflow: captured value > 99_999_999. Behaviour depends on DISP_SATURATE_EN (see Configuration).
- `start` while not in IDLE is ignored. It is not queued.
- `dig` is always < 10 in WRITE. `pos` is never 8..14.
- Reset mid-operation: state returns to IDLE immediately, `pos`=4'hF, and no further writes occur. Digits already written stay in the display controller.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `pos`=4'hF, `dig`=0, state IDLE.
- `start` accepted at edge 0 → CONVERT during cycles 1..VALUE_W (27).
- WRITE cycles 28..35, with `pos`=0..7 in order.
- `done` high in cycle 36. Next start can be accepted at edge 37.
- Total latency from start to done is VALUE_W+NUM_DIGITS+1 = 36 cycles with defaults.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `DISP_SATURATE_EN` defined:
  - An overflowing value is replaced by 99_999_999 at capture.
  - `err`=1 and the normal sequence runs, writing eight 9s.
- Not defined:
  - Overflow sets `err`=1 and the block skips CONVERT and WRITE.
  - It goes straight to DONE (`done` at cycle 1) and writes nothing.

## Structure
- Shared package `disp_pkg`:
  - `disp_state_t` enum (IDLE, CONVERT, WRITE, DONE).
  - Constants `DISP_NUM_DIGITS`=8, `DISP_POS_IDLE`=4'hF, `DISP_MAX_VALUE`=99_999_999.
- One sub-module, `bcd_add3`: a combinational per-nibble "≥5 → +3" corrector, instantiated NUM_DIGITS times inside the CONVERT datapath.

## Test plan
- start with value=12_345_678:
  - `busy` rises at cycle 1.
  - Writes (pos,dig) = (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1) in cycles 28..35.
  - `done` at cycle 36; `err`=0.
- value=0: eight writes of `dig`=0 at `pos` 0..7; `done` at cycle 36.
- value=99_999_999: all eight digits = 9, `err`=0.
- value=100_000_000:
  - With DISP_SATURATE_EN: eight 9s, `err`=1.
  - Without it: no writes (`pos` stays 4'hF), `done` at cycle 1, `err`=1.
- Second `start` pulsed at cycle 10 with a different value: ignored, and the first value's digits are written unchanged.
- `reset` asserted low during the cycle-30 write: `pos`=4'hF and `busy`=0 immediately. No writes follow after release until a new start.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state type and constants for the display value sequencer
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE,
    DONE
  } disp_state_t;

  localparam int          DISP_NUM_DIGITS = 8;
  localparam logic [3:0]  DISP_POS_IDLE   = 4'hF;
  localparam int unsigned DISP_MAX_VALUE  = 99_999_999;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - per-nibble double-dabble corrector: nibbles of 5 or more get +3
module bcd_add3 (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/disp_value_seq.sv
// rtl/disp_value_seq.sv - binary to BCD converter streaming digits to the display controller
// Optional DISP_SATURATE_EN: clamp overflowing values to 99_999_999 instead of skipping the writes.
module disp_value_seq
  import disp_pkg::*;
#(
  parameter int VALUE_W    = 27,
  parameter int NUM_DIGITS = DISP_NUM_DIGITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         dig,
  output logic [3:0]         pos
);

  localparam int                 BCD_W    = 4 * NUM_DIGITS;
  localparam int                 CNT_W    = $clog2(VALUE_W);
  localparam logic [VALUE_W-1:0] MAX_VAL  = VALUE_W'(DISP_MAX_VALUE);
  localparam logic [3:0]         LAST_IDX = 4'(NUM_DIGITS - 1);

  disp_state_t        r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [VALUE_W-1:0] r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_idx;

  logic [BCD_W-1:0]   w_corr;
  logic [BCD_W-1:0]   w_bcd_next;
  logic               w_overflow;
  logic [VALUE_W-1:0] w_capture;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nibble (r_bcd[4*g +: 4]),
      .o_nibble (w_corr[4*g +: 4])
    );
  end

  assign w_bcd_next = {w_corr[BCD_W-2:0], r_bin[VALUE_W-1]};
  assign w_overflow = (value > MAX_VAL);

`ifdef DISP_SATURATE_EN
  assign w_capture = w_overflow ? MAX_VAL : value;
`else
  assign w_capture = value;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      dig     <= 4'd0;
      pos     <= DISP_POS_IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            err   <= w_overflow;
            r_bcd <= '0;
            r_bin <= w_capture;
            r_cnt <= CNT_W'(VALUE_W - 1);
            r_idx <= '0;
`ifdef DISP_SATURATE_EN
            r_state <= CONVERT;
            busy    <= 1'b1;
`else
            if (w_overflow) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              r_state <= CONVERT;
              busy    <= 1'b1;
            end
`endif
          end
        end
        CONVERT: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
          if (r_cnt == '0) begin
            // The first digit is presented on the same edge the last bit lands.
            r_state <= WRITE;
            r_idx   <= '0;
            pos     <= 4'd0;
            dig     <= w_bcd_next[3:0];
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pos     <= DISP_POS_IDLE;
            dig     <= 4'd0;
          end else begin
            // r_bcd shifts down so the next digit is always in bits [7:4].
            r_idx <= r_idx + 4'd1;
            pos   <= r_idx + 4'd1;
            dig   <= r_bcd[7:4];
            r_bcd <= {4'd0, r_bcd[BCD_W-1:4]};
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_value_seq.sv
// tb/tb_disp_value_seq.sv - directed table-driven bench for disp_value_seq
module tb_disp_value_seq;

  typedef struct {
    logic [26:0] val;
    logic [31:0] exp_bcd;
    logic        exp_err;
    logic        exp_skip;
    logic        inject;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [26:0] value = '0;
  logic        busy, done, err;
  logic [3:0]  dig, pos;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[7];

  disp_value_seq #(.VALUE_W(27), .NUM_DIGITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .dig   (dig),
    .pos   (pos)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [3:0] exp_dig;
    logic       bad;
    @(negedge clock);
    value = v.val;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    value = '0;
    if (v.exp_skip) begin
      chk($sformatf("v%0d_done_c1", id), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_busy_c1", id), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_err_c1", id), {31'd0, err}, 32'd1);
      bad = 1'b0;
      for (int c = 2; c <= 40; c++) begin
        @(negedge clock);
        if (pos !== 4'hF || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      end
      chk($sformatf("v%0d_no_writes", id), {31'd0, bad}, 32'd0);
      chk($sformatf("v%0d_err_sticky", id), {31'd0, err}, 32'd1);
    end else begin
      chk($sformatf("v%0d_busy_c1", id), {30'd0, busy, done}, 32'd2);
      for (int c = 2; c <= 36; c++) begin
        @(negedge clock);
        if (v.inject && c == 10) begin
          start = 1'b1;
          value = 27'd87_654_321;
        end
        if (v.inject && c == 11) begin
          start = 1'b0;
          value = '0;
        end
        if (c == 27)
          chk($sformatf("v%0d_pos_idle_c27", id), {28'd0, pos}, 32'hF);
        if (c >= 28 && c <= 35) begin
          exp_dig = v.exp_bcd[4*(c-28) +: 4];
          chk($sformatf("v%0d_write_c%0d", id, c), {24'd0, pos, dig},
              {24'd0, 4'(c - 28), exp_dig});
        end
        if (c == 35)
          chk($sformatf("v%0d_busy_c35", id), {30'd0, busy, done}, 32'd2);
        if (c == 36) begin
          chk($sformatf("v%0d_done_c36", id), {26'd0, done, busy, pos}, 32'h2F);
          chk($sformatf("v%0d_err", id), {31'd0, err}, {31'd0, v.exp_err});
        end
      end
      @(negedge clock);
      chk($sformatf("v%0d_done_c37", id), {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    logic seen;

    vecs[0] = '{27'd12_345_678, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{27'd0,          32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{27'd99_999_999, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
`ifdef DISP_SATURATE_EN
    vecs[3] = '{27'd100_000_000, 32'h9999_9999, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{27'd134_217_727, 32'h9999_9999, 1'b1, 1'b0, 1'b0};
`else
    vecs[3] = '{27'd100_000_000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{27'd134_217_727, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
`endif
    vecs[4] = '{27'd5_000_305,  32'h0500_0305, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{27'd10,         32'h0000_0010, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clock);
    chk("rst_outputs", {25'd0, busy, done, err, pos}, 32'h0F);
    chk("rst_dig", {28'd0, dig}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_after_rst", {26'd0, busy, done, pos}, 32'h0F);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset mid-write: cycle 30 is the pos=2 write of 12_345_678.
    @(negedge clock);
    value = 27'd12_345_678;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (29) @(negedge clock);
    chk("rst_mid_pre", {24'd0, pos, dig}, 32'h26);
    reset = 1'b0;
    #1;
    chk("rst_mid_async", {26'd0, busy, done, pos}, 32'h0F);
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      @(negedge clock);
      if (pos !== 4'hF || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    chk("rst_mid_no_writes", {31'd0, seen}, 32'd0);

    run_vec(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
